cluster_sequencer: RTL and testbench
====================================

CLUSTER_SEQUENCER -- requirements
Module: cluster_sequencer

Interface
REQ-001 SHALL have these parameters, one per line:
- CHUNK_SIZE, 128, bytes per chunk.
- BUS_SIZE, 8, bytes per beat.
- COMPUTE_UNIT_NUM, 32, number of filter chunks loaded.
- OUTPUT_BUF_NUM, 32, number of accumulator/output buffers.
- BEATS = CHUNK_SIZE/BUS_SIZE (16); CW = $clog2(BEATS); BW = $clog2(OUTPUT_BUF_NUM); UW = $clog2(COMPUTE_UNIT_NUM).
REQ-002 SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1, clock.
- RESET, in, 1, reset: synchronous, active-high.
- start_i, in, 1, begin a pass; sampled in IDLE.
- cfg_sub_chunk_num_i, in, BW+1, IFM sub-chunks per pass; valid range 1..OUTPUT_BUF_NUM.
- busy_o, out, 1, high when not in IDLE.
- done_o, out, 1, one-cycle pulse at end of pass.
- fil_beat_valid_i, in, 1, filter source beat available.
- fil_beat_ready_o, out, 1, filter beat accepted.
- ifm_beat_valid_i, in, 1, IFM source beat available.
- ifm_beat_ready_o, out, 1, IFM beat accepted.
- fil_chunk_wr_valid_o, out, 1, cluster filter write strobe.
- fil_chunk_wr_count_o, out, CW, filter beat index.
- fil_chunk_wr_sel_o, out, 1, filter write bank.
- fil_chunk_rd_sel_o, out, 1, filter read bank.
- fil_wr_order_sel_o, out, UW, target compute unit.
- ifm_chunk_wr_valid_o, out, 1, cluster IFM write strobe.
- ifm_chunk_wr_count_o, out, CW, IFM beat index.
- ifm_chunk_wr_sel_o, out, 1, IFM write bank.
- ifm_chunk_rd_sel_o, out, 1, IFM read bank.
- init_o, out, 1, cluster init (filter load phase).
- sub_chunk_start_o, out, 1, one-cycle compute start pulse.
- sub_chunk_end_i, in, 1, cluster compute-complete pulse.
- acc_buf_sel_o, out, BW, accumulator buffer index.
- out_buf_sel_o, out, BW, output buffer index.

Function
REQ-003 FSM states SHALL be IDLE, FIL_LOAD, RUN, DONE.
REQ-004 IDLE -> FIL_LOAD SHALL occur on start_i=1 with cfg_sub_chunk_num_i in 1..OUTPUT_BUF_NUM; N is latched at that edge; start_i with any other value SHALL be ignored.
REQ-005 fil_beat_ready_o SHALL equal (state==FIL_LOAD); fil_chunk_wr_valid_o SHALL equal fil_beat_valid_i & fil_beat_ready_o (combinational).
REQ-006 Each accepted filter beat SHALL increment fil_chunk_wr_count_o (wraps at BEATS); on beat BEATS-1, fil_wr_order_sel_o SHALL increment.
REQ-007 After beat BEATS-1 of unit COMPUTE_UNIT_NUM-1, the FSM SHALL go to RUN next cycle, with fil_wr_order_sel_o wrapped to 0.
REQ-008 init_o SHALL be 1 in FIL_LOAD and 0 otherwise; fil_chunk_wr_sel_o and fil_chunk_rd_sel_o SHALL be constant 0.
REQ-009 In RUN, the IFM loader SHALL keep full[1:0] flags and a loaded count. ifm_beat_ready_o = (state==RUN) & !full[ifm_chunk_wr_sel_o] & (loaded < N). ifm_chunk_wr_valid_o = ifm_beat_valid_i & ifm_beat_ready_o.
REQ-010 Each accepted IFM beat SHALL increment ifm_chunk_wr_count_o. On beat BEATS-1, at the same edge: full[wr_sel] set, wr_sel toggles, loaded increments, count wraps to 0.
REQ-011 Compute scheduler: when !computing & full[ifm_chunk_rd_sel_o] & issued < N, sub_chunk_start_o SHALL pulse for exactly one cycle, with computing set and issued incremented at that edge.
REQ-012 The first start SHALL come no earlier than the cycle after the edge that set full[rd_sel] (one cycle latency).
REQ-013 sub_chunk_end_i while computing SHALL, at the same edge: clear full[rd_sel], toggle ifm_chunk_rd_sel_o, increment acc_buf_sel_o and out_buf_sel_o (modulo OUTPUT_BUF_NUM, always equal), increment completed, and clear computing.
REQ-014 sub_chunk_end_i while !computing SHALL be ignored.
REQ-015 The next start SHALL be no earlier than the cycle after an end, giving a minimum one-cycle gap.
REQ-016 Loader and compute SHALL overlap: the next chunk loads into the idle bank while the other bank computes.
REQ-017 A set and a clear in the same cycle SHALL target different banks by construction (set requires !full, clear requires full); both SHALL take effect.
REQ-018 When completed reaches N, the FSM SHALL enter DONE; DONE SHALL assert done_o for one cycle, then return to IDLE. acc/out selects are retained and continue from that value on the next pass.
REQ-019 start_i outside IDLE SHALL be ignored; busy_o = (state != IDLE).

Reset
REQ-020 RESET=1 at a clock edge, in any state including mid-load or mid-compute, SHALL:
- force IDLE;
- clear all counters, selects, full flags, computing, issued, completed and loaded;
- deassert all outputs.
REQ-021 After RESET, the first sub_chunk_start_o SHALL NOT occur until a new start_i.

Verification
REQ-022 Filter load: start_i with cfg=1, fil valid held high -> exactly 512 fil_chunk_wr_valid_o cycles; fil_wr_order_sel_o steps 0..31 every 16 beats; init_o=1 throughout; RUN entered on cycle 513.
REQ-023 Single sub-chunk: cfg=1, IFM valid always high -> 16 IFM beats into bank 0; start pulse on the cycle after beat 16; end after 20 cycles -> acc/out sel=1, rd_sel=1, done_o one cycle later.
REQ-024 Ping-pong: cfg=4, end 30 cycles after each start -> chunk 1 loads into bank 1 during compute 0; starts exactly 1 cycle after each end; done_o after the 4th end; acc_buf_sel_o=4.
REQ-025 Back-pressure: source valid toggles 1/0, compute 5 cycles -> ready drops while both banks are full; no beat lost or duplicated; wr_count never skips.
REQ-026 Wrap: cfg=32 run twice -> acc/out sel reach 0 after the 32nd end and pass 2 starts at 0; a spurious sub_chunk_end_i while idle in RUN causes no change.
REQ-027 Mid-run RESET during chunk 2 compute -> all outputs 0 next cycle; a new start_i completes a full pass normally.

Source files
------------

// File: rtl/cluster_sequencer.sv
// Cluster sequencer: loads filter chunks into the compute units, then streams IFM sub-chunks
// through a two-bank ping-pong buffer while scheduling compute and accumulator buffers.
module cluster_sequencer #(
    parameter int CHUNK_SIZE       = 128,
    parameter int BUS_SIZE         = 8,
    parameter int COMPUTE_UNIT_NUM = 32,
    parameter int OUTPUT_BUF_NUM   = 32,
    localparam int BEATS = CHUNK_SIZE / BUS_SIZE,
    localparam int CW    = $clog2(BEATS),
    localparam int BW    = $clog2(OUTPUT_BUF_NUM),
    localparam int UW    = $clog2(COMPUTE_UNIT_NUM)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          start_i,
    input  logic [BW:0]   cfg_sub_chunk_num_i,
    output logic          busy_o,
    output logic          done_o,
    input  logic          fil_beat_valid_i,
    output logic          fil_beat_ready_o,
    input  logic          ifm_beat_valid_i,
    output logic          ifm_beat_ready_o,
    output logic          fil_chunk_wr_valid_o,
    output logic [CW-1:0] fil_chunk_wr_count_o,
    output logic          fil_chunk_wr_sel_o,
    output logic          fil_chunk_rd_sel_o,
    output logic [UW-1:0] fil_wr_order_sel_o,
    output logic          ifm_chunk_wr_valid_o,
    output logic [CW-1:0] ifm_chunk_wr_count_o,
    output logic          ifm_chunk_wr_sel_o,
    output logic          ifm_chunk_rd_sel_o,
    output logic          init_o,
    output logic          sub_chunk_start_o,
    input  logic          sub_chunk_end_i,
    output logic [BW-1:0] acc_buf_sel_o,
    output logic [BW-1:0] out_buf_sel_o
);

    typedef enum logic [1:0] {StIdle, StFilLoad, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [BW:0]   n_q, n_d;
    logic [BW:0]   loaded_q, loaded_d;
    logic [BW:0]   issued_q, issued_d;
    logic [BW:0]   completed_q, completed_d;
    logic [CW-1:0] fil_cnt_q, fil_cnt_d;
    logic [UW-1:0] fil_unit_q, fil_unit_d;
    logic [CW-1:0] ifm_cnt_q, ifm_cnt_d;
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [1:0]    full_q, full_d;
    logic          computing_q, computing_d;
    logic [BW-1:0] buf_sel_q, buf_sel_d;
    logic          end_fire;
    logic          cfg_ok;

    assign busy_o               = (state_q != StIdle);
    assign done_o               = (state_q == StDone);
    assign init_o               = (state_q == StFilLoad);
    assign fil_beat_ready_o     = (state_q == StFilLoad);
    assign fil_chunk_wr_valid_o = fil_beat_valid_i & fil_beat_ready_o;
    assign fil_chunk_wr_count_o = fil_cnt_q;
    assign fil_wr_order_sel_o   = fil_unit_q;
    assign fil_chunk_wr_sel_o   = 1'b0;
    assign fil_chunk_rd_sel_o   = 1'b0;
    assign ifm_beat_ready_o     = (state_q == StRun) & ~full_q[wr_sel_q] & (loaded_q < n_q);
    assign ifm_chunk_wr_valid_o = ifm_beat_valid_i & ifm_beat_ready_o;
    assign ifm_chunk_wr_count_o = ifm_cnt_q;
    assign ifm_chunk_wr_sel_o   = wr_sel_q;
    assign ifm_chunk_rd_sel_o   = rd_sel_q;
    assign sub_chunk_start_o    = (state_q == StRun) & ~computing_q & full_q[rd_sel_q] &
                                  (issued_q < n_q);
    assign acc_buf_sel_o        = buf_sel_q;
    assign out_buf_sel_o        = buf_sel_q;

    // computing is only ever set in RUN, so this also masks ends in other states
    assign end_fire = sub_chunk_end_i & computing_q;
    assign cfg_ok   = (cfg_sub_chunk_num_i != '0) &&
                      (cfg_sub_chunk_num_i <= (BW+1)'(OUTPUT_BUF_NUM));

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        loaded_d    = loaded_q;
        issued_d    = issued_q;
        completed_d = completed_q;
        fil_cnt_d   = fil_cnt_q;
        fil_unit_d  = fil_unit_q;
        ifm_cnt_d   = ifm_cnt_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        full_d      = full_q;
        computing_d = computing_q;
        buf_sel_d   = buf_sel_q;

        unique case (state_q)
            StIdle: begin
                if (start_i && cfg_ok) begin
                    state_d     = StFilLoad;
                    n_d         = cfg_sub_chunk_num_i;
                    loaded_d    = '0;
                    issued_d    = '0;
                    completed_d = '0;
                    full_d      = '0;
                    computing_d = 1'b0;
                    fil_cnt_d   = '0;
                    fil_unit_d  = '0;
                    ifm_cnt_d   = '0;
                end
            end
            StFilLoad: begin
                if (fil_chunk_wr_valid_o) begin
                    if (fil_cnt_q == CW'(BEATS - 1)) begin
                        fil_cnt_d = '0;
                        if (fil_unit_q == UW'(COMPUTE_UNIT_NUM - 1)) begin
                            fil_unit_d = '0;
                            state_d    = StRun;
                        end else begin
                            fil_unit_d = fil_unit_q + UW'(1);
                        end
                    end else begin
                        fil_cnt_d = fil_cnt_q + CW'(1);
                    end
                end
            end
            StRun: begin
                if (ifm_chunk_wr_valid_o) begin
                    if (ifm_cnt_q == CW'(BEATS - 1)) begin
                        ifm_cnt_d        = '0;
                        full_d[wr_sel_q] = 1'b1;
                        wr_sel_d         = ~wr_sel_q;
                        loaded_d         = loaded_q + (BW+1)'(1);
                    end else begin
                        ifm_cnt_d = ifm_cnt_q + CW'(1);
                    end
                end
                if (sub_chunk_start_o) begin
                    computing_d = 1'b1;
                    issued_d    = issued_q + (BW+1)'(1);
                end
                // A same-cycle set targets the write bank, which is never the full read bank
                if (end_fire) begin
                    full_d[rd_sel_q] = 1'b0;
                    rd_sel_d         = ~rd_sel_q;
                    buf_sel_d        = (buf_sel_q == BW'(OUTPUT_BUF_NUM - 1)) ? '0 :
                                       buf_sel_q + BW'(1);
                    completed_d      = completed_q + (BW+1)'(1);
                    computing_d      = 1'b0;
                    if ((completed_q + (BW+1)'(1)) == n_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            n_q         <= '0;
            loaded_q    <= '0;
            issued_q    <= '0;
            completed_q <= '0;
            fil_cnt_q   <= '0;
            fil_unit_q  <= '0;
            ifm_cnt_q   <= '0;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            full_q      <= '0;
            computing_q <= 1'b0;
            buf_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            loaded_q    <= loaded_d;
            issued_q    <= issued_d;
            completed_q <= completed_d;
            fil_cnt_q   <= fil_cnt_d;
            fil_unit_q  <= fil_unit_d;
            ifm_cnt_q   <= ifm_cnt_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            full_q      <= full_d;
            computing_q <= computing_d;
            buf_sel_q   <= buf_sel_d;
        end
    end

endmodule

// File: tb/tb_cluster_sequencer.sv
// Bench for cluster_sequencer: a count-based model of the pass (beats, chunks loaded,
// issued, completed) is compared with every output each cycle, plus literal spot checks.
module tb_cluster_sequencer;

    localparam int BEATS = 16;
    localparam int CU    = 32;
    localparam int OBN   = 32;
    localparam int CW    = 4;
    localparam int BW    = 5;
    localparam int UW    = 5;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          start_i = 1'b0;
    logic [BW:0]   cfg_sub_chunk_num_i = '0;
    logic          fil_beat_valid_i = 1'b0;
    logic          ifm_beat_valid_i = 1'b0;
    logic          sub_chunk_end_i = 1'b0;
    logic          busy_o, done_o, fil_beat_ready_o, ifm_beat_ready_o;
    logic          fil_chunk_wr_valid_o, fil_chunk_wr_sel_o, fil_chunk_rd_sel_o;
    logic [CW-1:0] fil_chunk_wr_count_o, ifm_chunk_wr_count_o;
    logic [UW-1:0] fil_wr_order_sel_o;
    logic          ifm_chunk_wr_valid_o, ifm_chunk_wr_sel_o, ifm_chunk_rd_sel_o;
    logic          init_o, sub_chunk_start_o;
    logic [BW-1:0] acc_buf_sel_o, out_buf_sel_o;

    cluster_sequencer dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .start_i              (start_i),
        .cfg_sub_chunk_num_i  (cfg_sub_chunk_num_i),
        .busy_o               (busy_o),
        .done_o               (done_o),
        .fil_beat_valid_i     (fil_beat_valid_i),
        .fil_beat_ready_o     (fil_beat_ready_o),
        .ifm_beat_valid_i     (ifm_beat_valid_i),
        .ifm_beat_ready_o     (ifm_beat_ready_o),
        .fil_chunk_wr_valid_o (fil_chunk_wr_valid_o),
        .fil_chunk_wr_count_o (fil_chunk_wr_count_o),
        .fil_chunk_wr_sel_o   (fil_chunk_wr_sel_o),
        .fil_chunk_rd_sel_o   (fil_chunk_rd_sel_o),
        .fil_wr_order_sel_o   (fil_wr_order_sel_o),
        .ifm_chunk_wr_valid_o (ifm_chunk_wr_valid_o),
        .ifm_chunk_wr_count_o (ifm_chunk_wr_count_o),
        .ifm_chunk_wr_sel_o   (ifm_chunk_wr_sel_o),
        .ifm_chunk_rd_sel_o   (ifm_chunk_rd_sel_o),
        .init_o               (init_o),
        .sub_chunk_start_o    (sub_chunk_start_o),
        .sub_chunk_end_i      (sub_chunk_end_i),
        .acc_buf_sel_o        (acc_buf_sel_o),
        .out_buf_sel_o        (out_buf_sel_o)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 filter load, 2 run, 3 done
    int m_ph = 0, m_n = 0, m_fil = 0, m_ld = 0, m_cmp = 0, m_iss = 0, m_base = 0, m_sel = 0;
    int   e_loaded;
    logic e_comp, e_ifm_rdy, e_start;
    assign e_loaded  = m_ld / BEATS;
    assign e_comp    = (m_iss > m_cmp);
    assign e_ifm_rdy = (m_ph == 2) && (e_loaded - m_cmp < 2) && (e_loaded < m_n);
    assign e_start   = (m_ph == 2) && !e_comp && (e_loaded > m_cmp) && (m_iss < m_n);

    logic s_rdy, s_start, s_comp;
    always @(posedge CLK) begin
        s_rdy   = e_ifm_rdy;
        s_start = e_start;
        s_comp  = e_comp;
        if (RESET) begin
            m_ph = 0; m_n = 0; m_fil = 0; m_ld = 0; m_cmp = 0; m_iss = 0; m_base = 0; m_sel = 0;
        end else begin
            case (m_ph)
                0: if (start_i && cfg_sub_chunk_num_i >= 1 && cfg_sub_chunk_num_i <= OBN) begin
                    m_base = (m_base + e_loaded) % 2;
                    m_ph = 1; m_n = int'(cfg_sub_chunk_num_i);
                    m_fil = 0; m_ld = 0; m_cmp = 0; m_iss = 0;
                end
                1: if (fil_beat_valid_i) begin
                    m_fil++;
                    if (m_fil == BEATS * CU) m_ph = 2;
                end
                2: begin
                    if (ifm_beat_valid_i && s_rdy) m_ld++;
                    if (s_start) m_iss++;
                    if (sub_chunk_end_i && s_comp) begin
                        m_cmp++;
                        m_sel = (m_sel + 1) % OBN;
                        if (m_cmp == m_n) m_ph = 3;
                    end
                end
                default: m_ph = 0;
            endcase
        end
    end

    bit chk_en = 0;
    int cyc = 0, fil_seen = 0, first_ifm = -1, starts_seen = 0;
    always @(negedge CLK) begin
        cyc++;
        if (fil_chunk_wr_valid_o) fil_seen++;
        if (ifm_chunk_wr_valid_o && first_ifm < 0) first_ifm = cyc;
        if (sub_chunk_start_o) starts_seen++;
        if (chk_en) begin
            check("busy", busy_o, m_ph != 0);
            check("done", done_o, m_ph == 3);
            check("init", init_o, m_ph == 1);
            check("fil_ready", fil_beat_ready_o, m_ph == 1);
            check("fil_wr_valid", fil_chunk_wr_valid_o, fil_beat_valid_i && m_ph == 1);
            check("fil_count", fil_chunk_wr_count_o, m_fil % BEATS);
            check("fil_unit", fil_wr_order_sel_o, (m_fil / BEATS) % CU);
            check("fil_banks", {fil_chunk_wr_sel_o, fil_chunk_rd_sel_o}, 0);
            check("ifm_ready", ifm_beat_ready_o, e_ifm_rdy);
            check("ifm_wr_valid", ifm_chunk_wr_valid_o, ifm_beat_valid_i && e_ifm_rdy);
            check("ifm_count", ifm_chunk_wr_count_o, m_ld % BEATS);
            check("ifm_wr_sel", ifm_chunk_wr_sel_o, (m_base + e_loaded) % 2);
            check("ifm_rd_sel", ifm_chunk_rd_sel_o, (m_base + m_cmp) % 2);
            check("start", sub_chunk_start_o, e_start);
            check("acc_sel", acc_buf_sel_o, m_sel);
            check("out_sel", out_buf_sel_o, m_sel);
        end
    end

    // Source valids: 0 held high, 1 toggling, 2 random
    int vmode = 0;
    int vtog = 0;
    always @(posedge CLK) begin
        #1;
        vtog = 1 - vtog;
        case (vmode)
            0: begin fil_beat_valid_i = 1'b1; ifm_beat_valid_i = 1'b1; end
            1: begin fil_beat_valid_i = vtog[0]; ifm_beat_valid_i = vtog[0]; end
            default: begin
                fil_beat_valid_i = 1'($urandom % 2);
                ifm_beat_valid_i = 1'($urandom % 2);
            end
        endcase
    end

    // Compute responder: end arrives lat cycles after each observed start
    int lat = 20, cd = 0, spur = 0;
    always @(posedge CLK) begin
        #2;
        sub_chunk_end_i = (cd == 1) || (spur != 0 && cd == 0 && ($urandom % 8) == 0);
        if (cd > 0) cd--;
        if (sub_chunk_start_o) cd = lat;
        if (RESET) cd = 0;
    end

    int s_cyc = 0, done_cyc = 0;

    task automatic do_reset();
        @(posedge CLK); #1 RESET = 1'b1;
        @(posedge CLK); #1 RESET = 1'b0;
    endtask

    task automatic pulse_start(input int n);
        @(posedge CLK); #1 start_i = 1'b1; cfg_sub_chunk_num_i = (BW+1)'(n);
        @(negedge CLK); #1 s_cyc = cyc;
        @(posedge CLK); #1 start_i = 1'b0; cfg_sub_chunk_num_i = '0;
    endtask

    task automatic wait_done(input int lim);
        bit found = 0;
        for (int i = 0; i < lim && !found; i++) begin
            @(negedge CLK); #1;
            if (done_o) begin found = 1; done_cyc = cyc; end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL done_timeout: got no done within %0d cycles, required done", lim);
        end
    endtask

    initial begin
        @(posedge CLK); #1 chk_en = 1;
        @(posedge CLK); #1 RESET = 1'b0;
        @(negedge CLK); #1;
        check("reset_busy", busy_o, 0);
        check("reset_acc", acc_buf_sel_o, 0);

        // Out-of-range configurations are ignored
        vmode = 0; lat = 20; spur = 0;
        pulse_start(0);
        pulse_start(33);
        repeat (3) @(negedge CLK);
        #1 check("bad_cfg_ignored", busy_o, 0);

        // Single sub-chunk with full filter load
        fil_seen = 0; first_ifm = -1; starts_seen = 0;
        pulse_start(1);
        wait_done(3000);
        check("fil_beats", fil_seen, 512);
        check("run_entry_cycle", first_ifm - s_cyc, 513);
        check("single_done_cycle", done_cyc - s_cyc, 550);
        check("single_acc", acc_buf_sel_o, 1);
        check("single_rd_sel", ifm_chunk_rd_sel_o, 1);
        check("single_starts", starts_seen, 1);
        @(negedge CLK); #1 check("done_one_cycle", done_o, 0);

        // Ping-pong over four sub-chunks
        do_reset();
        lat = 30; starts_seen = 0;
        pulse_start(4);
        wait_done(3000);
        check("pp_done_cycle", done_cyc - s_cyc, 653);
        check("pp_acc", acc_buf_sel_o, 4);
        check("pp_starts", starts_seen, 4);

        // Back-pressure with toggling sources, plus an ignored start mid-run
        vmode = 1; lat = 5;
        pulse_start(6);
        repeat (600) @(posedge CLK);
        pulse_start(3);
        wait_done(20000);
        check("bp_acc", acc_buf_sel_o, 10);

        // Randomised passes with spurious ends
        vmode = 2; spur = 1;
        for (int p = 0; p < 3; p++) begin
            lat = 1 + int'($urandom % 12);
            pulse_start(1 + int'($urandom % 8));
            wait_done(20000);
        end

        // Wrap of the buffer selects over two full-depth passes
        do_reset();
        vmode = 0; lat = 3; spur = 1;
        pulse_start(32);
        wait_done(5000);
        check("wrap_acc_pass1", acc_buf_sel_o, 0);
        pulse_start(32);
        wait_done(5000);
        check("wrap_acc_pass2", out_buf_sel_o, 0);

        // Reset in the middle of chunk 2 compute
        do_reset();
        lat = 30; spur = 0; starts_seen = 0;
        pulse_start(4);
        for (int i = 0; i < 2000 && starts_seen < 3; i++) @(negedge CLK);
        check("mid_reached_chunk2", starts_seen, 3);
        repeat (5) @(posedge CLK);
        do_reset();
        @(negedge CLK); #1;
        check("mid_busy", busy_o, 0);
        check("mid_acc", acc_buf_sel_o, 0);
        check("mid_rd_sel", ifm_chunk_rd_sel_o, 0);
        check("mid_wr_sel", ifm_chunk_wr_sel_o, 0);
        check("mid_ifm_cnt", ifm_chunk_wr_count_o, 0);
        check("mid_init", init_o, 0);
        starts_seen = 0;
        repeat (40) @(negedge CLK);
        #1 check("mid_no_start", starts_seen, 0);
        pulse_start(2);
        wait_done(3000);
        check("mid_new_pass_acc", acc_buf_sel_o, 2);

        repeat (2) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
